// File: rtl/ov7670_emulador.sv
// OV7670 sensor emulator, transmit side of the camera capture interface.
// Emits PCLK (clk/2), VSYNC, HREF and an 8-bit bus carrying RGB565 test
// frames, two bytes per pixel, high byte first.
// Optional feature: define OV7670_EMU_HSYNC_EN to add an hsync output that
// is high during the horizontal blanking slots of every line.
module ov7670_emulador #(
    parameter int H_ACTIVE      = 160,
    parameter int H_BLANK       = 32,
    parameter int V_SYNC_LINES  = 3,
    parameter int V_BACK_LINES  = 2,
    parameter int V_ACTIVE      = 120,
    parameter int V_FRONT_LINES = 2
) (
    input  logic        clk,
    input  logic        async_reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        busy,
`ifdef OV7670_EMU_HSYNC_EN
    output logic        hsync,
`endif
    output logic        frame_done
);

    localparam int LINE_SLOTS = 2 * H_ACTIVE + H_BLANK;
    localparam int ACT_SLOTS  = 2 * H_ACTIVE;
    localparam int BAR_W      = H_ACTIVE / 8;
    localparam int MAX_A      = (V_SYNC_LINES > V_BACK_LINES) ? V_SYNC_LINES : V_BACK_LINES;
    localparam int MAX_B      = (V_ACTIVE > V_FRONT_LINES) ? V_ACTIVE : V_FRONT_LINES;
    localparam int MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int SW         = $clog2(LINE_SLOTS);
    localparam int LW         = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int BW         = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        ACTIVE = 3'd3,
        VFRONT = 3'd4
    } state_t;

    // Index of the final line of each vertical region.
    function automatic logic [LW-1:0] last_line_of(input state_t st);
        case (st)
            VSYNC:   last_line_of = LW'(V_SYNC_LINES - 1);
            VBACK:   last_line_of = LW'(V_BACK_LINES - 1);
            ACTIVE:  last_line_of = LW'(V_ACTIVE - 1);
            VFRONT:  last_line_of = LW'(V_FRONT_LINES - 1);
            default: last_line_of = LW'(0);
        endcase
    endfunction

    // RGB565 colour of each of the eight vertical bars, left to right.
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    state_t          state_r;
    logic            ph_r;
    logic [SW-1:0]   slot_r;
    logic [LW-1:0]   line_r;
    logic [2:0]      bar_idx_r;
    logic [BW-1:0]   bar_cnt_r;
    logic [1:0]      pat_r;
    logic [15:0]     solid_r;

    logic            vsync_r;
    logic            href_r;
    logic [7:0]      data_r;
    logic            busy_r;
    logic            frame_done_r;

    state_t          nxt_state_s;
    logic [SW-1:0]   nxt_slot_s;
    logic [LW-1:0]   nxt_line_s;
    logic [2:0]      nxt_bar_idx_s;
    logic [BW-1:0]   nxt_bar_cnt_s;
    logic            last_slot_s;
    logic            last_line_s;
    logic            frame_end_s;
    logic            adv_s;

    logic            in_active_s;
    logic            vsync_s;
    logic            href_s;
    logic [7:0]      data_s;
    logic [15:0]     pix_s;

    // A new slot begins on every edge in IDLE and on every ph=1 edge while busy.
    assign adv_s       = (state_r == IDLE) || ph_r;
    assign frame_end_s = (state_r == VFRONT) && last_slot_s && last_line_s;

    // Position of the slot that starts at the next slot boundary.
    always_comb begin
        nxt_state_s   = state_r;
        nxt_slot_s    = slot_r;
        nxt_line_s    = line_r;
        nxt_bar_idx_s = bar_idx_r;
        nxt_bar_cnt_s = bar_cnt_r;
        last_slot_s   = (slot_r == SW'(LINE_SLOTS - 1));
        last_line_s   = (line_r == last_line_of(state_r));
        if (state_r == IDLE) begin
            nxt_slot_s    = SW'(0);
            nxt_line_s    = LW'(0);
            nxt_bar_idx_s = 3'd0;
            nxt_bar_cnt_s = BW'(0);
            if (enable) begin
                nxt_state_s = VSYNC;
            end else begin
                nxt_state_s = IDLE;
            end
        end else if (last_slot_s) begin
            nxt_slot_s    = SW'(0);
            nxt_bar_idx_s = 3'd0;
            nxt_bar_cnt_s = BW'(0);
            if (last_line_s) begin
                nxt_line_s = LW'(0);
                case (state_r)
                    VSYNC:   nxt_state_s = VBACK;
                    VBACK:   nxt_state_s = ACTIVE;
                    ACTIVE:  nxt_state_s = VFRONT;
                    VFRONT:  nxt_state_s = enable ? VSYNC : IDLE;
                    default: nxt_state_s = IDLE;
                endcase
            end else begin
                nxt_line_s = line_r + LW'(1);
            end
        end else begin
            nxt_slot_s = slot_r + SW'(1);
            // A pixel ends after its odd (low) byte; the bar advances every BAR_W pixels.
            if (slot_r[0]) begin
                if (bar_cnt_r == BW'(BAR_W - 1)) begin
                    nxt_bar_cnt_s = BW'(0);
                    nxt_bar_idx_s = bar_idx_r + 3'd1;
                end else begin
                    nxt_bar_cnt_s = bar_cnt_r + BW'(1);
                end
            end else begin
                nxt_bar_cnt_s = bar_cnt_r;
                nxt_bar_idx_s = bar_idx_r;
            end
        end
    end

    // Interface values for the upcoming slot.
    always_comb begin
        in_active_s = (int'(nxt_slot_s) < ACT_SLOTS);
        vsync_s     = (nxt_state_s == VSYNC);
        href_s      = (nxt_state_s == ACTIVE) && in_active_s;
        pix_s       = 16'h0000;
        data_s      = 8'h00;
        if (href_s) begin
            case (pat_r)
                2'd0: data_s = 8'(nxt_slot_s);
                2'd1: data_s = nxt_slot_s[0] ? solid_r[7:0] : solid_r[15:8];
                2'd2: begin
                    pix_s  = bar_color(nxt_bar_idx_s);
                    data_s = nxt_slot_s[0] ? pix_s[7:0] : pix_s[15:8];
                end
                2'd3: data_s = 8'(nxt_line_s);
                default: data_s = 8'h00;
            endcase
        end else begin
            data_s = 8'h00;
        end
    end

    // Slot position, pclk phase and the settings latched at frame start.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_r   <= IDLE;
            ph_r      <= 1'b0;
            slot_r    <= SW'(0);
            line_r    <= LW'(0);
            bar_idx_r <= 3'd0;
            bar_cnt_r <= BW'(0);
            pat_r     <= 2'd0;
            solid_r   <= 16'h0000;
        end else if (adv_s) begin
            state_r   <= nxt_state_s;
            ph_r      <= 1'b0;
            slot_r    <= nxt_slot_s;
            line_r    <= nxt_line_s;
            bar_idx_r <= nxt_bar_idx_s;
            bar_cnt_r <= nxt_bar_cnt_s;
            if (((state_r == IDLE) || frame_end_s) && enable) begin
                pat_r   <= pattern_sel;
                solid_r <= solid_color;
            end else begin
                pat_r   <= pat_r;
                solid_r <= solid_r;
            end
        end else begin
            ph_r <= 1'b1;
        end
    end

    // Registered interface outputs; they only change where a slot begins.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            vsync_r      <= 1'b0;
            href_r       <= 1'b0;
            data_r       <= 8'h00;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= !ph_r && frame_end_s;
            if (adv_s) begin
                vsync_r <= vsync_s;
                href_r  <= href_s;
                data_r  <= data_s;
                busy_r  <= (nxt_state_s != IDLE);
            end
        end
    end

`ifdef OV7670_EMU_HSYNC_EN
    logic hsync_r;

    // Horizontal blanking marker, same slot timing as href.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            hsync_r <= 1'b0;
        end else if (adv_s) begin
            hsync_r <= (nxt_state_s != IDLE) && !in_active_s;
        end
    end

    assign hsync = hsync_r;
`endif

    assign pclk       = ph_r;
    assign vsync      = vsync_r;
    assign href       = href_r;
    assign data       = data_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule
